// File: rtl/snn_lif_neuron_core.sv
// snn_lif_neuron_core: leaky integrate-and-fire neuron, two-stage pipeline.
// Define SNN_LIF_REFRACTORY_EN to build the post-spike refractory FSM.
module snn_lif_neuron_core #(
  parameter int VW         = 24,
  parameter int THRESH     = 1000,
  parameter int V_RESET    = 0,
  parameter int LEAK_SHIFT = 4,
  parameter int REFRAC_CYC = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [15:0]          ES_plus_reg,
  input  logic [15:0]          ES_minus_reg,
  input  logic [15:0]          IS_plus_reg,
  input  logic [15:0]          IS_minus_reg,
  output logic                 spike,
  output logic signed [VW-1:0] v_mem,
  output logic                 refractory,
  output logic [15:0]          spike_count
);

  localparam int W2 = VW + 2;

  localparam logic signed [VW-1:0] TH_V  = VW'(THRESH);
  localparam logic signed [VW-1:0] RST_V = VW'(V_RESET);
  localparam logic signed [VW-1:0] V_MAX =
    {1'b0, {(VW-1){1'b1}}};
  localparam logic signed [VW-1:0] V_MIN =
    {1'b1, {(VW-1){1'b0}}};
  localparam logic signed [W2-1:0] W_MAX = W2'(V_MAX);
  localparam logic signed [W2-1:0] W_MIN = W2'(V_MIN);

  logic signed [17:0]   es_diff;
  logic signed [17:0]   is_diff;
  logic signed [17:0]   i_net_d;
  logic signed [17:0]   i_net_q;
  logic                 s1_valid;

  logic signed [VW-1:0] leak;
  logic signed [W2-1:0] v_sum;
  logic signed [VW-1:0] v_clamp;
  logic                 fire;
  logic                 integ_en;
  logic                 take;

  // Stage 1: net synaptic current, 18 bits so it never overflows
  always_comb begin
    es_diff = $signed({2'b00, ES_plus_reg})
            - $signed({2'b00, ES_minus_reg});
    is_diff = $signed({2'b00, IS_plus_reg})
            - $signed({2'b00, IS_minus_reg});
    i_net_d = es_diff - is_diff;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_net_q  <= '0;
      s1_valid <= 1'b0;
    end else begin
      i_net_q  <= i_net_d;
      s1_valid <= in_valid;
    end
  end

  // Stage 2 datapath: leak, integrate, clamp, threshold on clamped value
  always_comb begin
    leak    = v_mem >>> LEAK_SHIFT;
    v_sum   = W2'(v_mem) - W2'(leak) + W2'(i_net_q);
    v_clamp = v_sum[VW-1:0];
    unique case (1'b1)
      (v_sum > W_MAX): v_clamp = V_MAX;
      (v_sum < W_MIN): v_clamp = V_MIN;
      default:         v_clamp = v_sum[VW-1:0];
    endcase
    fire = (v_clamp >= TH_V);
  end

  assign take = integ_en & s1_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      v_mem       <= RST_V;
      spike       <= 1'b0;
      spike_count <= '0;
    end else begin
      spike <= take & fire;
      if (!integ_en) begin
        v_mem <= RST_V;
      end else if (take) begin
        v_mem <= fire ? RST_V : v_clamp;
      end
      if (take && fire && spike_count != 16'hFFFF) begin
        spike_count <= spike_count + 16'd1;
      end
    end
  end

`ifdef SNN_LIF_REFRACTORY_EN
  localparam int CW =
    (REFRAC_CYC > 2) ? $clog2(REFRAC_CYC) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    CW'((REFRAC_CYC > 0) ? REFRAC_CYC - 1 : 0);

  typedef enum logic {
    ST_INTEG,
    ST_REFRAC
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INTEG;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter runs REFRAC_CYC-1 down to 0, so the window is REFRAC_CYC cycles
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    integ_en = 1'b0;
    unique case (state_q)
      ST_INTEG: begin
        integ_en = 1'b1;
        if (s1_valid && fire && REFRAC_CYC > 0) begin
          state_d = ST_REFRAC;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_REFRAC: begin
        if (cnt_q == '0) begin
          state_d = ST_INTEG;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_INTEG;
    endcase
  end

  assign refractory = (state_q == ST_REFRAC);
`else
  logic unused_refrac;

  assign unused_refrac = (REFRAC_CYC != 0);
  assign integ_en      = 1'b1;
  assign refractory    = 1'b0;
`endif

endmodule

// File: tb/tb_snn_lif_neuron_core.sv
// tb_snn_lif_neuron_core: vector table, corner sequences and a random run
// compared against an arithmetic neuron model (two DUT widths).
module tb_snn_lif_neuron_core;

  localparam int VW  = 24;
  localparam int SVW = 16;
  localparam int TH  = 1000;
  localparam int RC  = 3;
`ifdef SNN_LIF_REFRACTORY_EN
  localparam int REF_EN = 1;
`else
  localparam int REF_EN = 0;
`endif

  logic           clk      = 1'b0;
  logic           reset    = 1'b1;
  logic           in_valid = 1'b0;
  logic [15:0]    esp      = '0;
  logic [15:0]    esm      = '0;
  logic [15:0]    isp      = '0;
  logic [15:0]    ism      = '0;
  logic           spike;
  logic           refractory;
  logic [VW-1:0]  v_mem;
  logic [15:0]    spike_count;
  logic           s_spike;
  logic           s_refractory;
  logic [SVW-1:0] s_v_mem;
  logic [15:0]    s_spike_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  snn_lif_neuron_core #(
    .VW(VW), .THRESH(TH), .V_RESET(0),
    .LEAK_SHIFT(4), .REFRAC_CYC(RC)
  ) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .ES_plus_reg(esp), .ES_minus_reg(esm),
    .IS_plus_reg(isp), .IS_minus_reg(ism),
    .spike(spike), .v_mem(v_mem),
    .refractory(refractory), .spike_count(spike_count)
  );

  snn_lif_neuron_core #(
    .VW(SVW), .THRESH(TH), .V_RESET(0),
    .LEAK_SHIFT(8), .REFRAC_CYC(RC)
  ) u_dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .ES_plus_reg(esp), .ES_minus_reg(esm),
    .IS_plus_reg(isp), .IS_minus_reg(ism),
    .spike(s_spike), .v_mem(s_v_mem),
    .refractory(s_refractory), .spike_count(s_spike_count)
  );

  // Model: a pending sample from last cycle, and a count of cycles
  // during which arriving samples are thrown away after a spike.
  typedef struct {
    longint v;
    int     cnt;
    int     blocked;
    bit     spk;
    bit     pend_v;
    longint pend_i;
  } mdl_t;

  mdl_t mb;
  mdl_t ms;

  function automatic longint floor_shr(longint v, int s);
    longint d;
    d = longint'(1) << s;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic mdl_t step(mdl_t m, bit rst, bit vld,
                                longint inet, int vw, int sh);
    mdl_t   n;
    longint hi;
    longint nv;
    n     = m;
    n.spk = 1'b0;
    hi    = (longint'(1) << (vw - 1)) - 1;
    if (rst) begin
      n = '{default: 0};
      return n;
    end
    if (m.blocked > 0) begin
      n.blocked = m.blocked - 1;
    end else if (m.pend_v) begin
      nv = m.v - floor_shr(m.v, sh) + m.pend_i;
      if (nv > hi) nv = hi;
      if (nv < -hi - 1) nv = -hi - 1;
      if (nv >= TH) begin
        n.spk = 1'b1;
        n.v   = 0;
        if (n.cnt < 65535) n.cnt = n.cnt + 1;
        n.blocked = (REF_EN != 0) ? RC : 0;
      end else begin
        n.v = nv;
      end
    end
    n.pend_v = vld;
    n.pend_i = inet;
    return n;
  endfunction

  function automatic longint cur_inet();
    return longint'(esp) - longint'(esm)
         - longint'(isp) + longint'(ism);
  endfunction

  always @(posedge clk) begin
    mb <= step(mb, reset, in_valid, cur_inet(), VW, 4);
    ms <= step(ms, reset, in_valid, cur_inet(), SVW, 8);
  end

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_spike", longint'(spike), longint'(mb.spk));
      chk("mdl_v", longint'($signed(v_mem)), mb.v);
      chk("mdl_refr", longint'(refractory),
          longint'(mb.blocked > 0));
      chk("mdl_cnt", longint'(spike_count), longint'(mb.cnt));
      chk("mdl_s_spike", longint'(s_spike), longint'(ms.spk));
      chk("mdl_s_v", longint'($signed(s_v_mem)), ms.v);
      chk("mdl_s_refr", longint'(s_refractory),
          longint'(ms.blocked > 0));
      chk("mdl_s_cnt", longint'(s_spike_count), longint'(ms.cnt));
    end
  end

  typedef struct {
    int ep;
    int em;
    int ip;
    int im;
    int ev;
    bit es;
    int ec;
  } vec_t;

  vec_t tbl[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    esp = '0;
    esm = '0;
    isp = '0;
    ism = '0;
  endtask

  initial begin
    int nspk;
    int nref;
    int pos_seen;

    tbl[0] = '{500,   0,   0, 0,     500,  1'b0, 0};
    tbl[1] = '{600,   0,   0, 0,     0,    1'b1, 1};
    tbl[2] = '{0,     0,   300, 0,   -300, 1'b0, 1};
    tbl[3] = '{0,     0,   0, 0,     -281, 1'b0, 1};
    tbl[4] = '{0,     100, 0, 50,    -313, 1'b0, 1};
    tbl[5] = '{65535, 0,   0, 65535, 0,    1'b1, 2};
    tbl[6] = '{1000,  0,   0, 0,     0,    1'b1, 3};
    tbl[7] = '{999,   0,   0, 0,     999,  1'b0, 3};
    tbl[8] = '{0,     0,   0, 0,     937,  1'b0, 3};
    tbl[9] = '{100,   0,   0, 0,     979,  1'b0, 3};

    // Reset held with live random traffic
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      esp = 16'($urandom_range(0, 65535));
      esm = 16'($urandom_range(0, 65535));
      isp = 16'($urandom_range(0, 65535));
      ism = 16'($urandom_range(0, 65535));
      tick();
      chk("rst_spike", longint'(spike), 0);
      chk("rst_v", longint'($signed(v_mem)), 0);
      chk("rst_refr", longint'(refractory), 0);
      chk("rst_cnt", longint'(spike_count), 0);
    end
    idle_in();
    reset  = 1'b0;
    chk_en = 1'b1;

    foreach (tbl[k]) begin
      in_valid = 1'b1;
      esp = 16'(tbl[k].ep);
      esm = 16'(tbl[k].em);
      isp = 16'(tbl[k].ip);
      ism = 16'(tbl[k].im);
      tick();
      idle_in();
      tick();
      chk("tbl_v", longint'($signed(v_mem)), tbl[k].ev);
      chk("tbl_spike", longint'(spike), longint'(tbl[k].es));
      chk("tbl_cnt", longint'(spike_count), tbl[k].ec);
      chk("tbl_refr", longint'(refractory),
          (tbl[k].es && REF_EN != 0) ? 1 : 0);
      repeat (3) tick();
    end

    // Back-to-back strong input right after a spike
    nspk = 0;
    nref = 0;
    in_valid = 1'b1;
    esp = 16'd2000;
    for (int i = 0; i < 4; i++) begin
      tick();
      nspk += int'(spike);
      nref += int'(refractory);
    end
    esp = 16'd100;
    tick();
    nspk += int'(spike);
    nref += int'(refractory);
    idle_in();
    repeat (3) begin
      tick();
      nspk += int'(spike);
      nref += int'(refractory);
    end
    chk("refr_spikes", nspk, (REF_EN != 0) ? 1 : 4);
    chk("refr_cycles", nref, (REF_EN != 0) ? RC : 0);
    chk("refr_v_after", longint'($signed(v_mem)), 100);
    chk("refr_cnt", longint'(spike_count),
        (REF_EN != 0) ? 4 : 7);

    // Reset one cycle after a spike
    in_valid = 1'b1;
    esp = 16'd2000;
    tick();
    idle_in();
    tick();
    chk("rm_spike", longint'(spike), 1);
    chk("rm_refr", longint'(refractory), REF_EN);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_refr_clr", longint'(refractory), 0);
    chk("rm_v_clr", longint'($signed(v_mem)), 0);
    chk("rm_cnt_clr", longint'(spike_count), 0);
    chk("rm_spike_clr", longint'(spike), 0);
    in_valid = 1'b1;
    esp = 16'd500;
    tick();
    idle_in();
    tick();
    chk("rm_integ_v", longint'($signed(v_mem)), 500);

    // Saturating inhibition from a clean state
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pos_seen = 0;
    nspk = 0;
    in_valid = 1'b1;
    isp = 16'hFFFF;
    for (int i = 0; i < 300; i++) begin
      tick();
      if ($signed(v_mem) > 0) pos_seen++;
      nspk += int'(spike) + int'(s_spike);
    end
    idle_in();
    chk("sat_pos_cycles", pos_seen, 0);
    chk("sat_spikes", nspk, 0);
    chk("sat_small_v", longint'($signed(s_v_mem)), -32768);

    // Random traffic, checked every cycle by the model
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 49) == 0);
      in_valid = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 15) == 0) begin
        esp = 16'($urandom_range(0, 65535));
        esm = 16'($urandom_range(0, 65535));
        isp = 16'($urandom_range(0, 65535));
        ism = 16'($urandom_range(0, 65535));
      end else begin
        esp = 16'($urandom_range(0, 1500));
        esm = 16'($urandom_range(0, 300));
        isp = 16'($urandom_range(0, 600));
        ism = 16'($urandom_range(0, 300));
      end
      tick();
    end
    reset = 1'b0;
    idle_in();
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
